regfile_write_arbiter: RTL and testbench

Arbiter and sequencer for the single write port of the 8×16-bit register file. It accepts write requests from `N_REQ` requesters, such as ALU writeback, memory load and debug/init, and grants them round-robin. It drives the register file's `LD_REG`/`DR`/`bus` inputs from registered outputs. It also runs a self-timed clear sequence that writes 16'h0000 to R0..R7.

---
 rtl/regfile_write_arbiter_if.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundle between the write requesters and the register-file write arbiter.
//   It also carries the register-file write port the arbiter drives.
//
//   Handshake: req[i] is a level request. The requester holds req[i],
//   req_dr[3i+:3] and req_data[DATA_W*i+:DATA_W] stable until it samples
//   ack[i] high at a rising edge. It may drop req[i] at that edge, or keep
//   it high to present its next write. ack[i] is a one-cycle pulse and is
//   only ever high together with LD_REG.
//
//   Signals:
//     req        requester -> arbiter  per-requester write request
//     req_dr     requester -> arbiter  destination register, 3 bits each
//     req_data   requester -> arbiter  write data, DATA_W bits each
//     clear_req  requester -> arbiter  start the R0..R7 clear sequence
//     ack        arbiter -> requester  one-hot grant pulse
//     clear_busy arbiter -> requester  high while the clear is running
//     clear_done arbiter -> requester  one-cycle pulse when the clear ends
//     LD_REG     arbiter -> regfile    write enable
//     DR         arbiter -> regfile    destination register
//     bus        arbiter -> regfile    write data
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req;
  logic [3*N_REQ-1:0]      req_dr;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    clear_req;
  logic                    clear_busy;
  logic                    clear_done;
  logic                    LD_REG;
  logic [2:0]              DR;
  logic [DATA_W-1:0]       bus;

  modport master (
    output req, req_dr, req_data, clear_req,
    input  ack, clear_busy, clear_done, LD_REG, DR, bus
  );

  modport slave (
    input  req, req_dr, req_data, clear_req,
    output ack, clear_busy, clear_done, LD_REG, DR, bus
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Round-robin arbiter and sequencer for the single write port of the
//   8x16 register file. It has two states:
//     ARB   - grants one eligible requester per cycle.
//     CLEAR - writes zero to R0..R7 on eight consecutive cycles.
//   All outputs toward the register file and the requesters are registered.
//
//   Ports:
//     CLK         clock, rising edge
//     Reset       synchronous, active-high reset
//     wr          regfile_write_arbiter_if.slave (requests, acks, clear
//                 control, LD_REG/DR/bus)
//     dbg_state_o current FSM state (0 = ARB, 1 = CLEAR)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 16
) (
  input  logic                   CLK,
  input  logic                   Reset,
  regfile_write_arbiter_if.slave wr,
  output logic                   dbg_state_o
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [3:0]          cnt_q;
  logic [N_REQ-1:0]    ack_q;
  logic                ld_q;
  logic [2:0]          dr_q;
  logic [DATA_W-1:0]   bus_q;
  logic                done_q;

  logic [N_REQ-1:0]    elig;
  logic [N_REQ-1:0]    gnt_oh;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [2:0]          gnt_dr;
  logic [DATA_W-1:0]   gnt_data;
  logic                arb_now;

  // Round-robin pick. A requester acked this cycle is masked so that a
  // still-held req is not granted twice for the same write. The first pass
  // looks above the pointer. The second pass wraps to the lowest eligible
  // index, which is at or below the pointer whenever the first pass misses.
  always_comb begin
    elig     = wr.req & ~ack_q;
    gnt_vld  = 1'b0;
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_dr   = '0;
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && elig[i] && (i > int'(ptr_q))) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_dr    = wr.req_dr[3*i +: 3];
        gnt_data  = wr.req_data[DATA_W*i +: DATA_W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && elig[i]) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_dr    = wr.req_dr[3*i +: 3];
        gnt_data  = wr.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // A normal arbitration happens in ARB without a clear request. It also
  // happens on the edge that ends a clear, so the done cycle can carry a write.
  assign arb_now = ((state_q == ST_ARB) && !wr.clear_req) ||
                   ((state_q == ST_CLEAR) && (cnt_q == 4'd8));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_ARB;
      ptr_q   <= PTR_W'(N_REQ - 1);
      cnt_q   <= 4'd0;
      ack_q   <= '0;
      ld_q    <= 1'b0;
      dr_q    <= 3'd0;
      bus_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (arb_now) begin
        if (state_q == ST_CLEAR) begin
          state_q <= ST_ARB;
          cnt_q   <= 4'd0;
          done_q  <= 1'b1;
        end
        if (gnt_vld) begin
          ld_q  <= 1'b1;
          dr_q  <= gnt_dr;
          bus_q <= gnt_data;
          ack_q <= gnt_oh;
          ptr_q <= gnt_idx;
        end else begin
          // DR and bus keep their last values while the port is idle.
          ld_q  <= 1'b0;
          ack_q <= '0;
        end
      end else if (state_q == ST_ARB) begin
        // The clear request wins over pending writes. R0 is written on this edge.
        state_q <= ST_CLEAR;
        cnt_q   <= 4'd1;
        ld_q    <= 1'b1;
        dr_q    <= 3'd0;
        bus_q   <= '0;
        ack_q   <= '0;
      end else begin
        ld_q  <= 1'b1;
        dr_q  <= cnt_q[2:0];
        bus_q <= '0;
        ack_q <= '0;
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign wr.ack        = ack_q;
  assign wr.LD_REG     = ld_q;
  assign wr.DR         = dr_q;
  assign wr.bus        = bus_q;
  assign wr.clear_busy = (state_q == ST_CLEAR);
  assign wr.clear_done = done_q;
  assign dbg_state_o   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed scenarios followed by a randomized phase. Each cycle, every
//   output is compared with a reference model. The model describes the
//   arbiter as "round robin from the last winner, skip whoever is acked
//   now" and "a queue of eight clear writes".
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int N = 3;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic Reset;
  logic dbg_state;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  regfile_write_arbiter_if #(.N_REQ(N), .DATA_W(W)) wr();

  regfile_write_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .wr          (wr),
    .dbg_state_o (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- stimulus state and driver ----------------
  logic [N-1:0] r_req;
  logic [2:0]   r_dr   [N];
  logic [W-1:0] r_data [N];
  logic         r_clear;

  task automatic drive();
    wr.req       = r_req;
    wr.clear_req = r_clear;
    for (int i = 0; i < N; i++) begin
      wr.req_dr[3*i +: 3]   = r_dr[i];
      wr.req_data[W*i +: W] = r_data[i];
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_ld;
  logic [2:0]   m_dr;
  logic [W-1:0] m_bus;
  logic [N-1:0] m_ack;
  logic         m_busy;
  logic         m_done;
  int           m_last;
  int           clear_q[$];

  task automatic model_reset();
    m_ld = 1'b0; m_dr = 3'd0; m_bus = '0; m_ack = '0;
    m_busy = 1'b0; m_done = 1'b0; m_last = N - 1;
    clear_q.delete();
  endtask

  task automatic model_step();
    int prev;
    int g;
    int idx;
    prev = -1;
    for (int i = 0; i < N; i++) if (m_ack[i]) prev = i;
    if (Reset) begin
      model_reset();
    end else if (m_busy && clear_q.size() > 0) begin
      m_ld = 1'b1; m_dr = 3'(clear_q.pop_front()); m_bus = '0;
      m_ack = '0; m_done = 1'b0;
    end else if (!m_busy && r_clear) begin
      for (int k = 0; k < 8; k++) clear_q.push_back(k);
      m_busy = 1'b1; m_done = 1'b0;
      m_ld = 1'b1; m_dr = 3'(clear_q.pop_front()); m_bus = '0; m_ack = '0;
    end else begin
      m_done = m_busy;
      m_busy = 1'b0;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && r_req[idx] && idx != prev) g = idx;
      end
      if (g >= 0) begin
        m_ld = 1'b1; m_dr = r_dr[g]; m_bus = r_data[g];
        m_ack = '0; m_ack[g] = 1'b1; m_last = g;
      end else begin
        m_ld = 1'b0; m_ack = '0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ld_reg",     32'(wr.LD_REG),     32'(m_ld));
    check("dr",         32'(wr.DR),         32'(m_dr));
    check("bus",        32'(wr.bus),        32'(m_bus));
    check("ack",        32'(wr.ack),        32'(m_ack));
    check("clear_busy", 32'(wr.clear_busy), 32'(m_busy));
    check("clear_done", 32'(wr.clear_done), 32'(m_done));
    check("state",      32'(dbg_state),     32'(m_busy));
  endtask

  // Inputs change only after the falling edge; outputs are checked there.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    Reset   = 1'b1;
    r_req   = '0;
    r_clear = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_dr[i] = 3'd0; r_data[i] = '0;
    end
    drive();
    model_reset();

    // reset state
    repeat (2) cycle();
    check("rst_ld",  32'(wr.LD_REG), 32'd0);
    check("rst_ack", 32'(wr.ack),    32'd0);

    // single write
    Reset = 1'b0;
    r_req = 3'b001; r_dr[0] = 3'd3; r_data[0] = 16'hBEEF; drive();
    cycle();
    check("t1_ld",  32'(wr.LD_REG), 32'd1);
    check("t1_dr",  32'(wr.DR),     32'd3);
    check("t1_bus", 32'(wr.bus),    32'hBEEF);
    check("t1_ack", 32'(wr.ack),    32'b001);
    r_req = '0; drive();
    cycle();
    check("t1_ld_drop", 32'(wr.LD_REG), 32'd0);

    // three requesters always pending
    do_reset();
    r_req = 3'b111;
    for (int i = 0; i < N; i++) begin
      r_dr[i] = 3'(i + 1); r_data[i] = 16'($urandom);
    end
    drive();
    for (int n = 0; n < 6; n++) begin
      cycle();
      check("t2_order", 32'(wr.ack),    32'(1) << (n % 3));
      check("t2_ld",    32'(wr.LD_REG), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          r_dr[i] = 3'($urandom_range(0, 7)); r_data[i] = 16'($urandom);
        end
      end
      drive();
    end

    // lone requester holding req
    do_reset();
    r_req = 3'b010; r_dr[1] = 3'd6; r_data[1] = 16'h5A5A; drive();
    for (int n = 0; n < 6; n++) begin
      cycle();
      check("t3_ack", 32'(wr.ack), (n % 2 == 0) ? 32'b010 : 32'b000);
    end
    r_req = '0; drive();
    cycle();

    // clear with a pending request
    do_reset();
    r_req = 3'b001; r_dr[0] = 3'd5; r_data[0] = 16'h1234; r_clear = 1'b1; drive();
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (n == 0) begin
        r_clear = 1'b0; drive();
      end
      check("t4_clr_dr",  32'(wr.DR),         32'(n));
      check("t4_clr_bus", 32'(wr.bus),        32'd0);
      check("t4_busy",    32'(wr.clear_busy), 32'd1);
      check("t4_noack",   32'(wr.ack),        32'd0);
    end
    cycle();
    check("t4_done",     32'(wr.clear_done), 32'd1);
    check("t4_ack",      32'(wr.ack),        32'b001);
    check("t4_dr",       32'(wr.DR),         32'd5);
    check("t4_bus",      32'(wr.bus),        32'h1234);
    check("t4_busy_end", 32'(wr.clear_busy), 32'd0);
    r_req = '0; drive();
    cycle();
    check("t4_done_pulse", 32'(wr.clear_done), 32'd0);

    // reset during the 4th clear write
    do_reset();
    r_req = 3'b111; r_clear = 1'b1; drive();
    cycle();
    r_clear = 1'b0; drive();
    cycle();
    cycle();
    cycle();
    check("t5_dr3", 32'(wr.DR), 32'd3);
    Reset = 1'b1;
    cycle();
    check("t5_rst_ld",   32'(wr.LD_REG),     32'd0);
    check("t5_rst_busy", 32'(wr.clear_busy), 32'd0);
    check("t5_rst_dr",   32'(wr.DR),         32'd0);
    Reset = 1'b0;
    cycle();
    check("t5_first_ack", 32'(wr.ack),        32'b001);
    check("t5_no_done",   32'(wr.clear_done), 32'd0);
    r_req = '0; drive();
    cycle();

    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
          else begin
            r_dr[i] = 3'($urandom_range(0, 7)); r_data[i] = 16'($urandom);
          end
        end else if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
          r_dr[i] = 3'($urandom_range(0, 7)); r_data[i] = 16'($urandom);
        end
      end
      r_clear = ($urandom_range(0, 24) == 0);
      Reset   = ($urandom_range(0, 99) == 0);
      drive();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
